conv3x3_pipe: RTL and testbench

//  Parametrised, pipelined 3x3 convolution engine with valid/ready flow control.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_mac9.sv | 67 ++++++
 rtl/conv3x3_pipe.sv | 160 ++++++++++++++++
 tb/tb_conv3x3_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution engine.
//   mode_e            : operating modes selected per window
//   NUM_TAPS          : taps per 3x3 window (k = row*3 + col)
//   KER_*             : preset kernels, element k is the coefficient for tap k
//   acc_w()           : accumulator width that holds any 9-tap sum without overflow
package conv_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'b00,
    MODE_SHARPEN = 2'b01,
    MODE_SOBEL   = 2'b10,
    MODE_USER    = 2'b11
  } mode_e;

  localparam int NUM_TAPS = 9;

  localparam int KER_IDENTITY [NUM_TAPS] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
  localparam int KER_SHARPEN  [NUM_TAPS] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
  localparam int KER_SOBEL_X  [NUM_TAPS] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int KER_SOBEL_Y  [NUM_TAPS] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  // Unsigned channel widened by one sign bit, times a signed coefficient,
  // summed over nine taps: four guard bits on top of the product width.
  function automatic int acc_w(input int ch_w, input int coef_w);
    return ch_w + coef_w + 5;
  endfunction

endpackage

// File: rtl/conv_mac9.sv
// One colour channel of the 3x3 convolution.
//   iClk   : clock
//   wAdv   : pipeline advance (clock enable and not stalled)
//   wPix   : nine unsigned channel samples, tap k at [k*CH_W +: CH_W]
//   wKer   : nine signed coefficients for the primary path, tap k at [k*COEF_W +: COEF_W]
//   wSumA  : primary 9-tap sum of the window two advances ago
//   wSumB  : Sobel-Y 9-tap sum of the same window (only consumed in Sobel mode)
// The Sobel-Y path uses constant coefficients so it collapses to shifts and adds.
module conv_mac9
  import conv_pkg::*;
#(
  parameter int CH_W   = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 21
) (
  input  logic                          iClk,
  input  logic                          wAdv,
  input  logic [NUM_TAPS*CH_W-1:0]      wPix,
  input  logic [NUM_TAPS*COEF_W-1:0]    wKer,
  output logic signed [ACC_W-1:0]       wSumA,
  output logic signed [ACC_W-1:0]       wSumB
);

  localparam int PROD_W = CH_W + 1 + COEF_W;

  logic signed [PROD_W-1:0] prod_a_p0 [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_b_p0 [NUM_TAPS];
  logic signed [ACC_W-1:0]  row_a_p1  [3];
  logic signed [ACC_W-1:0]  row_b_p1  [3];

  function automatic logic signed [PROD_W-1:0] mul(input logic [CH_W-1:0] pix,
                                                    input logic signed [PROD_W-1:0] coef);
    logic signed [PROD_W-1:0] px;
    px = PROD_W'({1'b0, pix});
    return px * coef;
  endfunction

  function automatic logic signed [ACC_W-1:0] widen(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // S1: tap products
  always_ff @(posedge iClk) begin
    if (wAdv) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        prod_a_p0[k] <= mul(wPix[k*CH_W +: CH_W],
                            {{(PROD_W-COEF_W){wKer[k*COEF_W+COEF_W-1]}}, wKer[k*COEF_W +: COEF_W]});
        prod_b_p0[k] <= mul(wPix[k*CH_W +: CH_W], PROD_W'(KER_SOBEL_Y[k]));
      end
    end
  end

  // S2: row partial sums
  always_ff @(posedge iClk) begin
    if (wAdv) begin
      for (int r = 0; r < 3; r++) begin
        row_a_p1[r] <= widen(prod_a_p0[3*r]) + widen(prod_a_p0[3*r+1]) + widen(prod_a_p0[3*r+2]);
        row_b_p1[r] <= widen(prod_b_p0[3*r]) + widen(prod_b_p0[3*r+1]) + widen(prod_b_p0[3*r+2]);
      end
    end
  end

  // S3 (combinational part): final sums feed the post-op in the top level
  assign wSumA = row_a_p1[0] + row_a_p1[1] + row_a_p1[2];
  assign wSumB = row_b_p1[0] + row_b_p1[1] + row_b_p1[2];

endmodule

// File: rtl/conv3x3_pipe.sv
// Pipelined 3x3 convolution engine with valid/ready flow control.
//   iClk / wRsn            : clock, synchronous active-low reset
//   wEnClk                 : clock enable, all state holds while low
//   wInValid / wInReady    : window handshake
//   wWin                   : 3x3 window, tap k at [k*PIX_W +: PIX_W], channel 0 in LSBs
//   wMode / wShift         : per-window mode and user-kernel right shift (sampled at accept)
//   wKerWe/Addr/Data       : write one shadow kernel coefficient
//   wKerCommit             : copy shadow kernel to the active kernel
//   wOutValid / wOutReady  : result handshake
//   wConvPixel             : filtered pixel
//   wBusy                  : some stage holds a valid window
// Three stages (products, row sums, final sum + post-op); a stalled output
// freezes all stages together so nothing is dropped or repeated.
module conv3x3_pipe
  import conv_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int CH_W    = 8,
  parameter int COEF_W  = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                         iClk,
  input  logic                         wRsn,
  input  logic                         wEnClk,
  input  logic                         wInValid,
  output logic                         wInReady,
  input  logic [NUM_TAPS*NUM_CH*CH_W-1:0] wWin,
  input  logic [1:0]                   wMode,
  input  logic [SHIFT_W-1:0]           wShift,
  input  logic                         wKerWe,
  input  logic [3:0]                   wKerAddr,
  input  logic [COEF_W-1:0]            wKerData,
  input  logic                         wKerCommit,
  output logic                         wOutValid,
  input  logic                         wOutReady,
  output logic [NUM_CH*CH_W-1:0]       wConvPixel,
  output logic                         wBusy
);

  localparam int PIX_W = NUM_CH * CH_W;
  localparam int ACC_W = acc_w(CH_W, COEF_W);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << CH_W) - 1);

  logic stall, adv, accept;
  logic vld_p0, vld_p1, vld_p2;
  mode_e mode_p0, mode_p1;
  logic [SHIFT_W-1:0] shift_p0, shift_p1;
  logic [NUM_TAPS-1:0][COEF_W-1:0] ker_shadow, ker_active, ker_sel;
  logic signed [ACC_W-1:0] sum_a [NUM_CH];
  logic signed [ACC_W-1:0] sum_b [NUM_CH];
  logic [PIX_W-1:0] pix_next;

  function automatic logic [NUM_TAPS-1:0][COEF_W-1:0] identity_bank();
    logic [NUM_TAPS-1:0][COEF_W-1:0] b;
    for (int k = 0; k < NUM_TAPS; k++) b[k] = COEF_W'(KER_IDENTITY[k]);
    return b;
  endfunction

  function automatic logic signed [ACC_W-1:0] abs_acc(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? -v : v;
  endfunction

  function automatic logic signed [ACC_W-1:0] post_op(input mode_e m, input logic [SHIFT_W-1:0] sh,
                                                      input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    case (m)
      MODE_SOBEL: return abs_acc(a) + abs_acc(b);
      MODE_USER:  return a >>> sh;
      default:    return a;
    endcase
  endfunction

  // Negative results (ReLU) and overflow both saturate into the channel range.
  function automatic logic [CH_W-1:0] clamp_px(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1])    return '0;
    if (v > PIX_MAX)   return '1;
    return v[CH_W-1:0];
  endfunction

  assign stall     = wOutValid && !wOutReady;
  assign wInReady  = !stall;
  assign adv       = wEnClk && !stall;
  assign accept    = wInValid && wInReady && wEnClk;
  assign wOutValid = vld_p2;
  assign wBusy     = vld_p0 | vld_p1 | vld_p2;

  // Commit copies the shadow contents from before any same-cycle write.
  always_ff @(posedge iClk) begin
    if (!wRsn) begin
      ker_shadow <= identity_bank();
      ker_active <= identity_bank();
    end else if (wEnClk) begin
      if (wKerWe && wKerAddr < 4'd9) ker_shadow[wKerAddr] <= wKerData;
      if (wKerCommit) ker_active <= ker_shadow;
    end
  end

  always_comb begin
    ker_sel = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      case (mode_e'(wMode))
        MODE_BYPASS:  ker_sel[k] = COEF_W'(KER_IDENTITY[k]);
        MODE_SHARPEN: ker_sel[k] = COEF_W'(KER_SHARPEN[k]);
        MODE_SOBEL:   ker_sel[k] = COEF_W'(KER_SOBEL_X[k]);
        default:      ker_sel[k] = ker_active[k];
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [NUM_TAPS*CH_W-1:0] taps;
    always_comb begin
      taps = '0;
      for (int k = 0; k < NUM_TAPS; k++) taps[k*CH_W +: CH_W] = wWin[k*PIX_W + c*CH_W +: CH_W];
    end
    conv_mac9 #(.CH_W(CH_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
      .iClk  (iClk),
      .wAdv  (adv),
      .wPix  (taps),
      .wKer  (ker_sel),
      .wSumA (sum_a[c]),
      .wSumB (sum_b[c])
    );
  end

  // S1/S2: stage valids and per-window mode/shift travel with the data
  always_ff @(posedge iClk) begin
    if (!wRsn) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge iClk) begin
    if (adv) begin
      mode_p0  <= mode_e'(wMode);
      shift_p0 <= wShift;
      mode_p1  <= mode_p0;
      shift_p1 <= shift_p0;
    end
  end

  // S3: post-op, clamp, output register
  always_comb begin
    pix_next = '0;
    for (int c = 0; c < NUM_CH; c++)
      pix_next[c*CH_W +: CH_W] = clamp_px(post_op(mode_p1, shift_p1, sum_a[c], sum_b[c]));
  end

  always_ff @(posedge iClk) begin
    if (!wRsn)                 wConvPixel <= '0;
    else if (adv && vld_p1)    wConvPixel <= pix_next;
  end

endmodule

// File: tb/tb_conv3x3_pipe.sv
module tb_conv3x3_pipe;

  localparam int PIX_W = 24;
  localparam int WIN_W = 9 * PIX_W;

  localparam int SHARP [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
  localparam int GX    [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int GY    [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  logic iClk = 1'b0;
  logic wRsn = 1'b0;
  logic wEnClk = 1'b1;
  logic wInValid = 1'b0;
  logic wInReady;
  logic [WIN_W-1:0] wWin = '0;
  logic [1:0] wMode = 2'd0;
  logic [3:0] wShift = 4'd0;
  logic wKerWe = 1'b0;
  logic [3:0] wKerAddr = 4'd0;
  logic [7:0] wKerData = 8'd0;
  logic wKerCommit = 1'b0;
  logic wOutValid;
  logic wOutReady = 1'b1;
  logic [PIX_W-1:0] wConvPixel;
  logic wBusy;

  int n_tests = 0;
  int n_fail = 0;
  int shad [9];
  int act  [9];

  conv3x3_pipe #(.NUM_CH(3), .CH_W(8), .COEF_W(8), .SHIFT_W(4)) dut (
    .iClk       (iClk),
    .wRsn       (wRsn),
    .wEnClk     (wEnClk),
    .wInValid   (wInValid),
    .wInReady   (wInReady),
    .wWin       (wWin),
    .wMode      (wMode),
    .wShift     (wShift),
    .wKerWe     (wKerWe),
    .wKerAddr   (wKerAddr),
    .wKerData   (wKerData),
    .wKerCommit (wKerCommit),
    .wOutValid  (wOutValid),
    .wOutReady  (wOutReady),
    .wConvPixel (wConvPixel),
    .wBusy      (wBusy)
  );

  always #5 iClk = ~iClk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain integer convolution per channel from the mode rules.
  function automatic logic [PIX_W-1:0] model(input logic [WIN_W-1:0] w, input int m, input int sh,
                                              input int uk [9]);
    logic [PIX_W-1:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      int a, b, v, p;
      a = 0; b = 0;
      for (int k = 0; k < 9; k++) begin
        p = int'(w[k*PIX_W + c*8 +: 8]);
        case (m)
          0: a += (k == 4) ? p : 0;
          1: a += SHARP[k] * p;
          2: begin a += GX[k] * p; b += GY[k] * p; end
          default: a += uk[k] * p;
        endcase
      end
      if (m == 2) v = (a < 0 ? -a : a) + (b < 0 ? -b : b);
      else if (m == 3) v = a >>> sh;
      else v = a;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      r[c*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  function automatic logic [WIN_W-1:0] rand_win();
    logic [WIN_W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = 24'($urandom);
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] fill_win(input logic [PIX_W-1:0] px);
    logic [WIN_W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = px;
    return w;
  endfunction

  // Offer one window on an idle pipeline; report readiness, valid one cycle
  // early, valid and pixel at the expected latency. Mode is scrambled after
  // acceptance so a late mode change must not leak into the result.
  task automatic send_wait(input logic [WIN_W-1:0] w, input logic [1:0] m, input logic [3:0] s,
                           output logic rdy, output logic early, output logic vld,
                           output logic [PIX_W-1:0] px);
    @(negedge iClk);
    wWin = w; wMode = m; wShift = s; wInValid = 1'b1; wOutReady = 1'b1;
    #1 rdy = wInReady;
    @(negedge iClk);
    wInValid = 1'b0; wWin = rand_win(); wMode = 2'($urandom); wShift = 4'($urandom);
    @(negedge iClk);
    early = wOutValid;
    @(negedge iClk);
    vld = wOutValid; px = wConvPixel;
    @(negedge iClk);
  endtask

  task automatic ker_write(input int addr, input int data, input bit commit);
    @(negedge iClk);
    wKerWe = 1'b1; wKerAddr = 4'(addr); wKerData = 8'(data); wKerCommit = commit;
    @(negedge iClk);
    wKerWe = 1'b0; wKerCommit = 1'b0;
    if (commit) act = shad;
    if (addr < 9) shad[addr] = data;
  endtask

  task automatic test_reset();
    wRsn = 1'b0;
    repeat (3) @(negedge iClk);
    n_tests++; if (wOutValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", wOutValid); end
    n_tests++; if (wBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", wBusy); end
    n_tests++; if (wConvPixel !== 24'h0) begin n_fail++; $display("FAIL reset_pixel got %h want 000000", wConvPixel); end
    n_tests++; if (wInReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", wInReady); end
    for (int k = 0; k < 9; k++) begin shad[k] = (k == 4); act[k] = (k == 4); end
    wRsn = 1'b1;
    @(negedge iClk);
  endtask

  task automatic test_bypass();
    logic [WIN_W-1:0] w; logic rdy, early, vld; logic [PIX_W-1:0] px;
    for (int i = 0; i < 3; i++) begin
      w = rand_win();
      w[4*PIX_W +: PIX_W] = 24'h123456;
      send_wait(w, 2'b00, 4'($urandom), rdy, early, vld, px);
      n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL bypass_ready got %b want 1", rdy); end
      n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL bypass_early_valid got %b want 0", early); end
      n_tests++; if (vld !== 1'b1) begin n_fail++; $display("FAIL bypass_valid_at_3 got %b want 1", vld); end
      n_tests++; if (px !== 24'h123456) begin n_fail++; $display("FAIL bypass_pixel got %h want 123456", px); end
    end
  endtask

  task automatic test_sharpen();
    logic [WIN_W-1:0] w; logic rdy, early, vld; logic [PIX_W-1:0] px, exp;
    send_wait(fill_win(24'h646464), 2'b01, 4'd0, rdy, early, vld, px);
    n_tests++; if (vld !== 1'b1 || px !== 24'h646464) begin n_fail++; $display("FAIL sharpen_flat got %b/%h want 1/646464", vld, px); end
    w = '0; w[4*PIX_W +: PIX_W] = 24'hFF0000;
    send_wait(w, 2'b01, 4'd0, rdy, early, vld, px);
    n_tests++; if (vld !== 1'b1 || px !== 24'hFF0000) begin n_fail++; $display("FAIL sharpen_clamp got %b/%h want 1/ff0000", vld, px); end
    w = fill_win(24'h0A0A0A); w[4*PIX_W +: PIX_W] = 24'h0;
    send_wait(w, 2'b01, 4'd0, rdy, early, vld, px);
    n_tests++; if (vld !== 1'b1 || px !== 24'h000000) begin n_fail++; $display("FAIL sharpen_relu got %b/%h want 1/000000", vld, px); end
    for (int i = 0; i < 3; i++) begin
      w = rand_win(); exp = model(w, 1, 0, act);
      send_wait(w, 2'b01, 4'($urandom), rdy, early, vld, px);
      n_tests++; if (vld !== 1'b1 || px !== exp) begin n_fail++; $display("FAIL sharpen_random got %b/%h want 1/%h", vld, px, exp); end
    end
  endtask

  task automatic test_sobel();
    logic [WIN_W-1:0] w; logic rdy, early, vld; logic [PIX_W-1:0] px, exp;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      w[(3*r+1)*PIX_W +: PIX_W] = 24'h404040;
      w[(3*r+2)*PIX_W +: PIX_W] = 24'hC8C8C8;
    end
    send_wait(w, 2'b10, 4'd0, rdy, early, vld, px);
    n_tests++; if (vld !== 1'b1 || px !== 24'hFFFFFF) begin n_fail++; $display("FAIL sobel_edge got %b/%h want 1/ffffff", vld, px); end
    send_wait(fill_win(24'($urandom)), 2'b10, 4'd0, rdy, early, vld, px);
    n_tests++; if (vld !== 1'b1 || px !== 24'h000000) begin n_fail++; $display("FAIL sobel_uniform got %b/%h want 1/000000", vld, px); end
    for (int i = 0; i < 3; i++) begin
      w = rand_win();
      for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = w[k*PIX_W +: PIX_W] & 24'h1F1F1F;
      exp = model(w, 2, 0, act);
      send_wait(w, 2'b10, 4'd0, rdy, early, vld, px);
      n_tests++; if (vld !== 1'b1 || px !== exp) begin n_fail++; $display("FAIL sobel_random got %b/%h want 1/%h", vld, px, exp); end
    end
  endtask

  task automatic test_user_kernel();
    logic [WIN_W-1:0] w; logic rdy, early, vld; logic [PIX_W-1:0] px, exp;
    int s;
    for (int k = 0; k < 9; k++) ker_write(k, 1, 1'b0);
    w = fill_win(24'h505050); exp = model(w, 3, 3, act);
    send_wait(w, 2'b11, 4'd3, rdy, early, vld, px);
    n_tests++; if (vld !== 1'b1 || px !== exp) begin n_fail++; $display("FAIL user_before_commit got %b/%h want 1/%h", vld, px, exp); end
    ker_write(12, 77, 1'b1);
    send_wait(w, 2'b11, 4'd3, rdy, early, vld, px);
    n_tests++; if (vld !== 1'b1 || px !== 24'h5A5A5A) begin n_fail++; $display("FAIL user_ones_shift3 got %b/%h want 1/5a5a5a", vld, px); end
    ker_write(0, 3, 1'b0);
    // write, commit and a window accepted all in the same cycle
    w = rand_win(); exp = model(w, 3, 0, act);
    @(negedge iClk);
    wKerWe = 1'b1; wKerAddr = 4'd0; wKerData = 8'hFE; wKerCommit = 1'b1;
    wWin = w; wMode = 2'b11; wShift = 4'd0; wInValid = 1'b1; wOutReady = 1'b1;
    #1;
    n_tests++; if (wInReady !== 1'b1) begin n_fail++; $display("FAIL commit_cycle_ready got %b want 1", wInReady); end
    act = shad; shad[0] = -2;
    @(negedge iClk);
    wKerWe = 1'b0; wKerCommit = 1'b0; wInValid = 1'b0;
    repeat (2) @(negedge iClk);
    n_tests++; if (wOutValid !== 1'b1 || wConvPixel !== exp) begin n_fail++; $display("FAIL commit_cycle_old_bank got %b/%h want 1/%h", wOutValid, wConvPixel, exp); end
    @(negedge iClk);
    s = $urandom_range(0, 3);
    w = rand_win(); exp = model(w, 3, s, act);
    send_wait(w, 2'b11, 4'(s), rdy, early, vld, px);
    n_tests++; if (vld !== 1'b1 || px !== exp) begin n_fail++; $display("FAIL commit_pre_write_shadow got %b/%h want 1/%h", vld, px, exp); end
    // kernel updates are ignored while the clock enable is low
    @(negedge iClk);
    wEnClk = 1'b0; wKerWe = 1'b1; wKerAddr = 4'd1; wKerData = 8'd5; wKerCommit = 1'b1;
    @(negedge iClk);
    wEnClk = 1'b1; wKerWe = 1'b0; wKerCommit = 1'b0;
    w = rand_win(); exp = model(w, 3, 0, act);
    send_wait(w, 2'b11, 4'd0, rdy, early, vld, px);
    n_tests++; if (vld !== 1'b1 || px !== exp) begin n_fail++; $display("FAIL enclk_hold_bank got %b/%h want 1/%h", vld, px, exp); end
    ker_write(0, 0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      s = $urandom_range(0, 2);
      w = rand_win(); exp = model(w, 3, s, act);
      send_wait(w, 2'b11, 4'(s), rdy, early, vld, px);
      n_tests++; if (vld !== 1'b1 || px !== exp) begin n_fail++; $display("FAIL user_negative_tap got %b/%h want 1/%h", vld, px, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [PIX_W-1:0] q [$];
    logic [WIN_W-1:0] w;
    int m, s, sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    w = rand_win(); m = $urandom_range(0, 3); s = $urandom_range(0, 4);
    while (got < 10 && cyc < 400) begin
      @(negedge iClk);
      cyc++;
      wOutReady = 1'($urandom_range(0, 1));
      if (sent < 10) begin
        wInValid = 1'b1; wWin = w; wMode = 2'(m); wShift = 4'(s);
      end else begin
        wInValid = 1'b0;
      end
      #1;
      n_tests++;
      if (wInReady !== !(wOutValid && !wOutReady)) begin
        n_fail++; $display("FAIL stall_ready got %b want %b", wInReady, !(wOutValid && !wOutReady));
      end
      if (wOutValid && wOutReady) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra got %h want none", wConvPixel);
        end else begin
          if (wConvPixel !== q[0]) begin n_fail++; $display("FAIL stream_order got %h want %h", wConvPixel, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      if (wInValid && wInReady) begin
        q.push_back(model(w, m, s, act));
        sent++;
        w = rand_win(); m = $urandom_range(0, 3); s = $urandom_range(0, 4);
      end
    end
    n_tests++;
    if (got != 10 || q.size() != 0 || sent != 10) begin
      n_fail++; $display("FAIL stream_count got %0d results %0d pending want 10 and 0", got, q.size());
    end
    wInValid = 1'b0; wOutReady = 1'b1;
    repeat (2) @(negedge iClk);
  endtask

  task automatic test_reset_midstream();
    logic [WIN_W-1:0] w; logic rdy, early, vld; logic [PIX_W-1:0] px, exp;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      wWin = rand_win(); wMode = 2'($urandom); wInValid = 1'b1; wOutReady = 1'b1;
    end
    @(negedge iClk);
    wInValid = 1'b0;
    n_tests++; if (wBusy !== 1'b1) begin n_fail++; $display("FAIL inflight_busy got %b want 1", wBusy); end
    wRsn = 1'b0;
    @(negedge iClk);
    n_tests++; if (wOutValid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", wOutValid); end
    n_tests++; if (wBusy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", wBusy); end
    wRsn = 1'b1;
    for (int k = 0; k < 9; k++) begin shad[k] = (k == 4); act[k] = (k == 4); end
    w = rand_win(); exp = model(w, 3, 0, act);
    send_wait(w, 2'b11, 4'd0, rdy, early, vld, px);
    n_tests++; if (vld !== 1'b1 || px !== exp) begin n_fail++; $display("FAIL midreset_identity_bank got %b/%h want 1/%h", vld, px, exp); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_sharpen();
    test_sobel();
    test_user_kernel();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
